// File: rtl/is_pkg_uart_controller.sv
// Shared types and constants for the UART controller.
// The receive FSM uses its own state type so its names never collide with
// the transmit FSM's states.
package is_pkg_uart_controller;

  // Width of one data character on the serial line.
  localparam int DATA_W = 8;

  // Receive FSM states:
  //   R_IDLE  - line idle, waiting for a falling edge
  //   RSTRB   - start-bit validation at half a bit period
  //   RDT     - data bits, LSB first
  //   RPARB   - parity bit (only when parity is enabled)
  //   RSTB    - first stop bit
  //   R_WEND  - framing error seen, wait for the line to return high
  typedef enum logic [2:0] {
    R_IDLE,
    RSTRB,
    RDT,
    RPARB,
    RSTB,
    R_WEND
  } rx_state_t;

  // Parity error test for a received character.
  // The XOR of the data bits and the parity bit must equal the parity
  // sense: 0 for even parity, 1 for odd parity.
  function automatic logic rx_parity_error(
    input logic [DATA_W-1:0] data,
    input logic              par_bit,
    input logic              odd
  );
    return ((^data) ^ par_bit) != odd;
  endfunction

endpackage

// File: rtl/is_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high serial lines and active-low
// flow-control inputs both come out of reset in their inactive level.
module is_sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; only q may be used by downstream logic.
  // NOTE: sequential state is written with non-blocking assignments so that
  // every flop samples its input from before the clock edge; a blocking '='
  // here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/is_uart_rx_fsm.sv
// UART receive FSM.
// Oversamples rxd_i with the rx_ce_i enable, validates the start bit at its
// middle, samples data, parity and stop bits at their middles and hands the
// character to the host through a valid/ack holding register with parity,
// framing and overrun indications.
module is_uart_rx_fsm
  import is_pkg_uart_controller::*;
#(
  parameter int OVS        = 16,   // rx_ce_i ticks per bit, power of 2, >= 8
  parameter bit PARITY_EN  = 1'b1, // a parity bit follows the data bits
  parameter bit PARITY_ODD = 1'b0  // 0 = even parity, 1 = odd parity
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rx_ce_i,
  input  logic              rxd_i,
  input  logic              rx_ack_i,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_data_en_o,
  output logic              rx_par_err_o,
  output logic              rx_frm_err_o,
  output logic              rx_ovr_o,
  output logic              rxct_r_o
);

  localparam int CW = $clog2(OVS);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Tick count at the middle of the start bit, and at the end of a full bit
  // period (which is the middle of the next bit, as counting starts mid-start).
  localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  // ---------------------------------------------------------------------------
  // Input synchroniser; every decision below uses rxd_s.
  // ---------------------------------------------------------------------------
  logic rxd_s;

  is_sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_rxd (
    .clk   (clk_i),
    .rst_n (rst_i),
    .d     (rxd_i),
    .q     (rxd_s)
  );

  // ---------------------------------------------------------------------------
  // FSM state and datapath registers
  // ---------------------------------------------------------------------------
  rx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_pend_q, par_pend_d;  // parity result for this frame
  logic              deliver;                 // stop bit sampled this cycle

  // State register plus bit/sample counters and the receive shift register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= R_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_pend_q <= par_pend_d;
    end
  end

  // Next-state and datapath update; nothing moves except on an oversample tick.
  always_comb begin
    // NOTE: every signal driven here receives a default first, so no path
    // through the case statement leaves a value unassigned and no latch is
    // inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_pend_d = par_pend_q;
    deliver    = 1'b0;

    if (rx_ce_i) begin
      unique case (state_q)
        R_IDLE: begin
          if (!rxd_s) begin
            state_d = RSTRB;
            cnt_d   = '0;
          end
        end

        RSTRB: begin
          if (cnt_q == CNT_HALF) begin
            cnt_d = '0;
            if (!rxd_s) begin
              // Still low at mid start bit: a real start bit.
              state_d    = RDT;
              bit_cnt_d  = '0;
              par_pend_d = 1'b0;
            end else begin
              // Line back high: a glitch, drop it silently.
              state_d = R_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RDT: begin
          cnt_d = cnt_q + 1'b1;  // wraps to 0 after CNT_LAST
          if (cnt_q == CNT_LAST) begin
            // LSB arrives first, so shift in at the MSB and move right.
            shift_d   = {rxd_s, shift_q[DATA_W-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              state_d = PARITY_EN ? RPARB : RSTB;
            end
          end
        end

        RPARB: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            par_pend_d = rx_parity_error(shift_q, rxd_s, PARITY_ODD);
            state_d    = RSTB;
          end
        end

        RSTB: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            // Only the first stop bit is checked; a second one simply looks
            // like idle line to R_IDLE.
            deliver = 1'b1;
            state_d = rxd_s ? R_IDLE : R_WEND;
          end
        end

        R_WEND: begin
          // A line stuck low must not be taken as a new start bit.
          if (rxd_s) begin
            state_d = R_IDLE;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = R_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Host-side holding register
  // ---------------------------------------------------------------------------

  // Delivery loads data and flags; ack clears the valid flag; a delivery onto
  // unacknowledged data raises a one-cycle overrun pulse. Delivery wins over a
  // simultaneous ack, and that ack also suppresses the overrun.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_data_o    <= '0;
      rx_data_en_o <= 1'b0;
      rx_par_err_o <= 1'b0;
      rx_frm_err_o <= 1'b0;
      rx_ovr_o     <= 1'b0;
    end else begin
      rx_ovr_o <= 1'b0;
      if (deliver) begin
        rx_data_o    <= shift_q;
        rx_par_err_o <= par_pend_q;
        rx_frm_err_o <= ~rxd_s;
        rx_data_en_o <= 1'b1;
        rx_ovr_o     <= rx_data_en_o & ~rx_ack_i;
      end else if (rx_ack_i) begin
        rx_data_en_o <= 1'b0;
      end
    end
  end

  // Ready only when idle and the holding register is empty.
  assign rxct_r_o = (state_q == R_IDLE) && !rx_data_en_o;

endmodule

// File: tb/tb_is_uart_rx_fsm.sv
// Self-checking bench for is_uart_rx_fsm.
// Frames are built bit by bit on the serial line; expected results come from
// a character-level model (population count parity, valid/ack bookkeeping).
module tb_is_uart_rx_fsm;
  import is_pkg_uart_controller::*;

  localparam int OVS        = 16;
  localparam bit PARITY_ODD = 1'b0;
  localparam int CE_DIV     = 4;   // clk cycles per oversample tick

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rx_ce;
  logic              rxd;
  logic              rx_ack;
  logic [DATA_W-1:0] rx_data;
  logic              rx_data_en;
  logic              rx_par_err;
  logic              rx_frm_err;
  logic              rx_ovr;
  logic              rxct_r;

  is_uart_rx_fsm #(
    .OVS        (OVS),
    .PARITY_EN  (1'b1),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .rx_ce_i      (rx_ce),
    .rxd_i        (rxd),
    .rx_ack_i     (rx_ack),
    .rx_data_o    (rx_data),
    .rx_data_en_o (rx_data_en),
    .rx_par_err_o (rx_par_err),
    .rx_frm_err_o (rx_frm_err),
    .rx_ovr_o     (rx_ovr),
    .rxct_r_o     (rxct_r)
  );

  always #5 clk = ~clk;

  // Free-running oversample enable, one cycle in CE_DIV.
  initial begin
    int div;
    div   = 0;
    rx_ce = 1'b0;
    forever begin
      @(negedge clk);
      div   = div + 1;
      rx_ce = ((div % CE_DIV) == 0);
    end
  end

  int errors    = 0;
  int checks    = 0;
  int ovr_seen  = 0;

  // Counts overrun pulses as they appear.
  always @(negedge clk) begin
    if (rx_ovr === 1'b1) ovr_seen++;
  end

  // Reference model of the holding register contents.
  logic [DATA_W-1:0] m_data;
  logic              m_en, m_par, m_frm;
  int                m_ovr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_par_err(input logic [DATA_W-1:0] d, input logic pbit);
    int ones;
    ones = $countones(d) + int'(pbit);
    return ((ones % 2) == 1) != PARITY_ODD;
  endfunction

  function automatic logic good_parity(input logic [DATA_W-1:0] d);
    return (($countones(d) % 2) == 1) ^ PARITY_ODD;
  endfunction

  task automatic model_reset();
    m_data = '0;
    m_en   = 1'b0;
    m_par  = 1'b0;
    m_frm  = 1'b0;
  endtask

  // Wait for n oversample ticks (posedges with rx_ce high).
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (rx_ce !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic drive(input logic b);
    @(negedge clk);
    rxd = b;
  endtask

  // One complete frame; the line is left at the stop-bit level afterwards.
  // With ack_at_dlv the ack pulse lands on the clock of the stop-bit sample,
  // which is OVS/2+1 ticks after the stop bit is driven.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit,
                            input logic sbit, input int nstop, input bit ack_at_dlv);
    tick(1);
    drive(1'b0);
    for (int j = 0; j < DATA_W; j++) begin
      tick(OVS);
      drive(d[j]);
    end
    tick(OVS);
    drive(pbit);
    tick(OVS);
    drive(sbit);
    if (ack_at_dlv) begin
      tick(OVS / 2);
      repeat (CE_DIV - 1) @(posedge clk);
      @(negedge clk);
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      tick(OVS - OVS / 2 - 1);
    end else begin
      tick(OVS);
    end
    if (sbit) tick(OVS * (nstop - 1));
    // Model: delivery onto unacked data overruns unless acked in that cycle.
    if (m_en && !ack_at_dlv) m_ovr++;
    m_data = d;
    m_par  = model_par_err(d, pbit);
    m_frm  = !sbit;
    m_en   = 1'b1;
  endtask

  task automatic ack();
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_en = 1'b0;
    check("ack_clears_en", rx_data_en, 1'b0);
  endtask

  task automatic check_out(input string tag, input bit idle);
    @(negedge clk);
    check({tag, "_data"}, rx_data, m_data);
    check({tag, "_en"},   rx_data_en, m_en);
    check({tag, "_par"},  rx_par_err, m_par);
    check({tag, "_frm"},  rx_frm_err, m_frm);
    check({tag, "_ovr"},  ovr_seen, m_ovr);
    check({tag, "_rxct"}, rxct_r, idle && !m_en);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data"}, rx_data, '0);
    check({tag, "_en"},   rx_data_en, 1'b0);
    check({tag, "_par"},  rx_par_err, 1'b0);
    check({tag, "_frm"},  rx_frm_err, 1'b0);
    check({tag, "_ovr"},  rx_ovr, 1'b0);
    check({tag, "_rxct"}, rxct_r, 1'b1);
  endtask

  // Watchdog: the directed sequence is bounded, so this only fires on a hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic              pbit;
    int                nstop;

    rst_n  = 1'b0;
    rxd    = 1'b1;
    rx_ack = 1'b0;
    m_ovr  = 0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(2);

    // 0xA5, correct even parity (0), two stop bits; held until ack.
    send_frame(8'hA5, 1'b0, 1'b1, 2, 1'b0);
    check_out("a5", 1'b1);
    ack();
    @(negedge clk);
    check("a5_data_hold", rx_data, 8'hA5);
    check("a5_rxct_after_ack", rxct_r, 1'b1);

    // 0x01 with parity bit 0: even parity needs 1, so a parity error.
    send_frame(8'h01, 1'b0, 1'b1, 1, 1'b0);
    check_out("par01", 1'b1);
    ack();

    // 0x3C with a low stop bit, line stays low: framing error, no retrigger.
    send_frame(8'h3C, good_parity(8'h3C), 1'b0, 1, 1'b0);
    check_out("frm3c", 1'b0);
    ack();
    tick(40);
    @(negedge clk);
    check("wend_no_second_en", rx_data_en, 1'b0);
    check("wend_not_ready", rxct_r, 1'b0);
    check("wend_no_ovr", ovr_seen, m_ovr);
    rxd = 1'b1;
    tick(3);
    @(negedge clk);
    check("wend_back_idle", rxct_r, 1'b1);

    // 4-tick low glitch on an idle line: rejected, nothing changes.
    tick(1);
    drive(1'b0);
    tick(4);
    drive(1'b1);
    tick(2 * OVS);
    check_out("glitch", 1'b1);

    // Two frames without ack: one overrun pulse, newest data kept.
    send_frame(8'h11, good_parity(8'h11), 1'b1, 1, 1'b0);
    send_frame(8'h22, good_parity(8'h22), 1'b1, 1, 1'b0);
    check_out("ovr", 1'b1);
    // Ack landing on the delivery cycle: no overrun, data stays valid.
    d = 8'($urandom);
    send_frame(d, good_parity(d), 1'b1, 1, 1'b1);
    check_out("ack_at_dlv", 1'b1);
    ack();

    // Random characters, random parity correctness and stop-bit count.
    for (int i = 0; i < 6; i++) begin
      d     = 8'($urandom);
      pbit  = good_parity(d) ^ 1'($urandom_range(0, 1));
      nstop = int'($urandom_range(1, 2));
      send_frame(d, pbit, 1'b1, nstop, 1'b0);
      check_out("rand", 1'b1);
      ack();
    end

    // Reset during data bit 3, with an unacked character held beforehand.
    send_frame(8'hC3, good_parity(8'hC3), 1'b1, 1, 1'b0);
    check_out("pre_rst", 1'b1);
    d = 8'h96;
    tick(1);
    drive(1'b0);
    for (int j = 0; j < 4; j++) begin
      tick(OVS);
      drive(d[j]);
    end
    tick(OVS / 2);
    @(negedge clk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    model_reset();
    @(negedge clk);
    check_reset_values("midrst");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    tick(2);

    // The next frame after reset is received normally.
    send_frame(8'h5A, good_parity(8'h5A), 1'b1, 1, 1'b0);
    check_out("post_rst", 1'b1);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/is_uart_rx_fsm.md
Name: is_uart_rx_fsm

Overview:
- Serial receive stage of the UART controller; the counterpart to the transmit FSM.
- Deserialises frames on rxd_i: start bit, DATA_W data bits LSB-first, optional parity, then stop bit(s).
- Oversamples the line using the 16x baud enable from the baud generator.
- Presents each received byte to the host-side controller through a valid/ack holding register, together with error flags.

Parameters:
- OVS, 16: rx_ce_i ticks per bit; must be a power of 2 and at least 8.
- PARITY_EN, 1: 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity; 1 = odd parity.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; asynchronous, active-low.
- rx_ce_i  in  1  oversample enable; one-cycle pulse at OVS x baud rate.
- rxd_i  in  1  asynchronous serial input; idles high.
- rx_ack_i  in  1  consumer has taken rx_data_o.
- rx_data_o  out  DATA_W  last received byte.
- rx_data_en_o  out  1  rx_data_o holds valid, unacknowledged data.
- rx_par_err_o  out  1  parity mismatch for the byte in rx_data_o.
- rx_frm_err_o  out  1  first stop bit sampled low for the byte in rx_data_o.
- rx_ovr_o  out  1  one-cycle pulse: a byte was overwritten before ack.
- rxct_r_o  out  1  ready to receive; high in IDLE when rx_data_en_o=0.

Behaviour:
- Reset values (asynchronous assertion):
  - state = IDLE, counters = 0, shift register = 0.
  - rx_data_o = 0, rx_data_en_o = 0, rx_par_err_o = 0, rx_frm_err_o = 0, rx_ovr_o = 0, rxct_r_o = 1.
  - Both synchroniser flops = 1.
- Input synchronisation:
  - rxd_i passes through a 2-flop synchroniser; rxd_s is the second flop.
  - All decisions use rxd_s. Latency from pin to rxd_s is 2 clk_i cycles.
- Tick rule: the sample counter (log2 OVS bits) and all state transitions advance only on cycles with rx_ce_i=1, except IDLE->IDLE holds and reset.
- IDLE:
  - On a tick with rxd_s=0: go to RSTRB, cnt=0.
- RSTRB (start-bit validation):
  - cnt increments each tick.
  - At cnt==OVS/2-1: if rxd_s=0, go to RDT with cnt=0 and bit_cnt=0; otherwise return to IDLE (glitch rejected, no output activity).
- RDT:
  - At cnt==OVS-1, sample rxd_s into the shift register MSB, shifting right (LSB-first reception), and increment bit_cnt. cnt wraps to 0.
  - After DATA_W samples: go to RPARB if PARITY_EN=1, else RSTB.
- RPARB:
  - At cnt==OVS-1, par_err = (XOR of data bits XOR sampled bit) != PARITY_ODD.
  - Then go to RSTB.
- RSTB:
  - At cnt==OVS-1, sample the first stop bit.
  - If 1: deliver the frame, go to IDLE.
  - If 0: deliver the frame with frm_err=1, go to WEND.
  - The second stop bit is not checked; the receiver accepts 1 or 2 stop bits.
- WEND: on a tick with rxd_s=1, go to IDLE. The line stuck low never retriggers reception.
- Delivery (the clock cycle of the stop sample, registered):
  - rx_data_o <= shift register; error flags updated; rx_data_en_o <= 1.
  - If rx_data_en_o was already 1 and rx_ack_i=0 in that cycle: rx_ovr_o = 1 for one cycle and the data is overwritten.
- Ack:
  - rx_ack_i=1 while rx_data_en_o=1 clears rx_data_en_o on the next edge. rx_data_o and the flags hold their values.
  - Ack coinciding with delivery: delivery wins, rx_data_en_o stays 1, no overrun pulse.
- Sample point: about mid-bit, given the start is detected within one tick of the falling edge.
- Reset mid-frame: the frame is abandoned, all outputs go to their reset values, and the next falling edge after reset is treated as a start bit.

Decomposition:
- Add to is_pkg_uart_controller:
  - rx_state_t enum {R_IDLE, RSTRB, RDT, RPARB, RSTB, R_WEND}, kept distinct from the TX state_t names.
  - Reuse of DATA_W.
- One sub-module is natural: is_sync_2ff, a 2-flop synchroniser with reset value 1. It is reusable for cts inputs.

Test Plan:
- Frame 0xA5 with even parity bit 0 and 2 stop bits, at OVS=16 ticks per bit -> rx_data_o=0xA5, rx_data_en_o=1, par_err=0, frm_err=0, rxct_r_o=0 until ack.
- Frame 0x01 sent with parity bit 0 (even parity expects 1) -> rx_data_o=0x01, rx_par_err_o=1; ack clears rx_data_en_o next cycle.
- Frame 0x3C with first stop bit 0, line then held low 40 ticks -> rx_frm_err_o=1, FSM stays in WEND, no second delivery; line high -> IDLE.
- Low glitch of 4 ticks on an idle line -> return to IDLE, rx_data_en_o stays 0, no flags change.
- Frames 0x11 then 0x22 with no ack -> one rx_ovr_o pulse at the second delivery, rx_data_o=0x22; ack in the same cycle as a delivery -> no overrun, en=1.
- rst_i driven low during data bit 3 of a frame -> all outputs at reset values; a following frame 0x5A is received correctly.
